// File: rtl/cnt_rx_pkg.sv
// Shared types and frame layout for the counter serial receiver.
// A frame is seven bytes: five 10-bit counters, a 3-bit trigger count and 3 pad bits.
package cnt_rx_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRx,
        StDone
    } rx_state_e;

    localparam int unsigned FRAME_BITS = 56;
    localparam int unsigned NUM_BYTES  = 7;
    localparam int unsigned CNT_W      = 6;

    localparam int unsigned CA_LSB   = 0;
    localparam int unsigned CB_LSB   = 10;
    localparam int unsigned CC_LSB   = 20;
    localparam int unsigned CD_LSB   = 30;
    localparam int unsigned CE_LSB   = 40;
    localparam int unsigned TRIG_LSB = 50;
    localparam int unsigned PAD_LSB  = 53;

    localparam logic [2:0]       PH_LAST  = 3'd7;
    localparam logic [2:0]       SEL_LAST = 3'(NUM_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS);

endpackage

// File: rtl/cnt_rx_phase.sv
// Mirror of the serializer's free-running bit position plus the frame bit counter.
module cnt_rx_phase
    import cnt_rx_pkg::*;
(
    input  logic             SPI_CLK,
    input  logic             RSTB,
    input  logic             cnt_clr_i,
    input  logic             cnt_inc_i,
    output logic [2:0]       ph_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic [2:0]       ph_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            ph_q  <= '0;
            cnt_q <= '0;
        end else begin
            ph_q <= ph_q + 3'd1;
            if (cnt_clr_i) begin
                cnt_q <= '0;
            end else if (cnt_inc_i) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign ph_o  = ph_q;
    assign cnt_o = cnt_q;

endmodule

// File: rtl/cnt_ser_receiver.sv
// Captures one 56-bit counter frame from the channel serializer per START request
// and holds the decoded fields until the consumer accepts them.
module cnt_ser_receiver
    import cnt_rx_pkg::*;
(
    input  logic       SPI_CLK,
    input  logic       RSTB,
    input  logic       START,
    input  logic       CNT_SER,
    output logic [2:0] SELECT_REG,
    output logic [9:0] CA_O,
    output logic [9:0] CB_O,
    output logic [9:0] CC_O,
    output logic [9:0] CD_O,
    output logic [9:0] CE_O,
    output logic [2:0] TRIG_CNT_O,
    output logic       DATA_VALID,
    input  logic       DATA_READY,
    output logic       BUSY,
    output logic       FRAME_ERR
);

    rx_state_e             state_q;
    logic [FRAME_BITS-1:0] frame_q;
    logic [FRAME_BITS-1:0] frame_shift;
    logic [2:0]            ph;
    logic [CNT_W-1:0]      cnt;
    logic                  rx_begin;
    logic                  cnt_inc;

    cnt_rx_phase u_phase (
        .SPI_CLK   (SPI_CLK),
        .RSTB      (RSTB),
        .cnt_clr_i (rx_begin),
        .cnt_inc_i (cnt_inc),
        .ph_o      (ph),
        .cnt_o     (cnt)
    );

    // A START landing on the PH=7 edge enters RX directly; waiting would cost a full byte.
    always_comb begin
        rx_begin    = (ph == PH_LAST) &&
                      ((state_q == StWait) || ((state_q == StIdle) && START));
        cnt_inc     = (state_q == StRx);
        frame_shift = {frame_q[FRAME_BITS-2:0], CNT_SER};
    end

    always_ff @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            state_q    <= StIdle;
            frame_q    <= '0;
            SELECT_REG <= '0;
            CA_O       <= '0;
            CB_O       <= '0;
            CC_O       <= '0;
            CD_O       <= '0;
            CE_O       <= '0;
            TRIG_CNT_O <= '0;
            DATA_VALID <= 1'b0;
            BUSY       <= 1'b0;
            FRAME_ERR  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (START) begin
                        SELECT_REG <= '0;
                        BUSY       <= 1'b1;
                        state_q    <= rx_begin ? StRx : StWait;
                    end
                end
                StWait: begin
                    if (rx_begin) begin
                        SELECT_REG <= '0;
                        state_q    <= StRx;
                    end
                end
                StRx: begin
                    // CNT=0 is the launch-only edge; nothing valid is on CNT_SER yet.
                    if (cnt != '0) begin
                        frame_q <= frame_shift;
                    end
                    if ((ph == PH_LAST) && (SELECT_REG < SEL_LAST)) begin
                        SELECT_REG <= SELECT_REG + 3'd1;
                    end
                    if (cnt == CNT_LAST) begin
                        CA_O       <= frame_shift[CA_LSB +: 10];
                        CB_O       <= frame_shift[CB_LSB +: 10];
                        CC_O       <= frame_shift[CC_LSB +: 10];
                        CD_O       <= frame_shift[CD_LSB +: 10];
                        CE_O       <= frame_shift[CE_LSB +: 10];
                        TRIG_CNT_O <= frame_shift[TRIG_LSB +: 3];
                        FRAME_ERR  <= |frame_shift[PAD_LSB +: 3];
                        DATA_VALID <= 1'b1;
                        BUSY       <= 1'b0;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    if (DATA_READY) begin
                        DATA_VALID <= 1'b0;
                        SELECT_REG <= '0;
                        state_q    <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_ser_receiver.sv
// Bench for cnt_ser_receiver: a behavioural channel serializer feeds random frames and
// the recovered fields, latency and handshake are compared with the configured source.
`timescale 1ns/1ps
module tb_cnt_ser_receiver;

    logic       SPI_CLK    = 1'b0;
    logic       RSTB       = 1'b1;
    logic       START      = 1'b0;
    logic       DATA_READY = 1'b0;
    logic       CNT_SER;
    logic [2:0] SELECT_REG;
    logic [9:0] CA_O, CB_O, CC_O, CD_O, CE_O;
    logic [2:0] TRIG_CNT_O;
    logic       DATA_VALID, BUSY, FRAME_ERR;

    int n_cmp = 0;
    int n_err = 0;

    cnt_ser_receiver dut (
        .SPI_CLK    (SPI_CLK),
        .RSTB       (RSTB),
        .START      (START),
        .CNT_SER    (CNT_SER),
        .SELECT_REG (SELECT_REG),
        .CA_O       (CA_O),
        .CB_O       (CB_O),
        .CC_O       (CC_O),
        .CD_O       (CD_O),
        .CE_O       (CE_O),
        .TRIG_CNT_O (TRIG_CNT_O),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .BUSY       (BUSY),
        .FRAME_ERR  (FRAME_ERR)
    );

    always #5 SPI_CLK = ~SPI_CLK;

    // Channel serializer model: byte k bit p is word bit 55-8k-p, launched on the PH=p edge.
    logic [9:0]  src_ca = '0, src_cb = '0, src_cc = '0, src_cd = '0, src_ce = '0;
    logic [2:0]  src_trig = '0, src_pad = '0;
    logic [55:0] src_word;
    logic [2:0]  src_ph;
    assign src_word = {src_pad, src_trig, src_ce, src_cd, src_cc, src_cb, src_ca};

    always @(posedge SPI_CLK or negedge RSTB) begin
        if (!RSTB) begin
            src_ph  <= 3'd0;
            CNT_SER <= 1'b0;
        end else begin
            src_ph  <= src_ph + 3'd1;
            CNT_SER <= (SELECT_REG < 3'd7) ?
                       src_word[55 - 8 * int'(SELECT_REG) - int'(src_ph)] : 1'b0;
        end
    end

    logic [52:0] dut_fields;
    logic [52:0] exp_fields;
    logic        exp_err;
    assign dut_fields = {CA_O, CB_O, CC_O, CD_O, CE_O, TRIG_CNT_O};

    int         cap_lat;
    logic       cap_busy;
    int         sel_bad;
    logic [2:0] sel_seq[$];

    function automatic logic [52:0] src_fields();
        return {src_ca, src_cb, src_cc, src_cd, src_ce, src_trig};
    endfunction

    task automatic set_src(input logic [9:0] ca, cb, cc, cd, ce, input logic [2:0] trig, pad);
        src_ca = ca; src_cb = cb; src_cc = cc; src_cd = cd; src_ce = ce;
        src_trig = trig; src_pad = pad;
    endtask

    task automatic rand_src();
        src_ca = 10'($urandom); src_cb = 10'($urandom); src_cc = 10'($urandom);
        src_cd = 10'($urandom); src_ce = 10'($urandom); src_trig = 3'($urandom);
    endtask

    task automatic wait_ph(input int p);
        @(negedge SPI_CLK);
        for (int i = 0; i < 8 && int'(src_ph) != p; i++) @(negedge SPI_CLK);
    endtask

    // START on the edge where PH=p; cap_lat counts edges including the START edge.
    task automatic capture(input int p, input bit poke_start);
        logic [2:0] prev;
        wait_ph(p);
        exp_fields = src_fields();
        exp_err    = |src_pad;
        sel_seq.delete();
        sel_bad = 0;
        prev    = SELECT_REG;
        START   = 1'b1;
        cap_lat = -1;
        for (int i = 1; i <= 200; i++) begin
            @(negedge SPI_CLK);
            START = poke_start && (i >= 20) && (i < 26);
            if (i == 1) cap_busy = BUSY;
            if (SELECT_REG != prev) begin
                sel_seq.push_back(SELECT_REG);
                if (src_ph != 3'd0) sel_bad++;
                prev = SELECT_REG;
            end
            if (DATA_VALID) begin
                cap_lat = i;
                break;
            end
        end
        START = 1'b0;
    endtask

    task automatic test_reset();
        #2 RSTB = 1'b0;
        #1;
        n_cmp++;
        if ({SELECT_REG, dut_fields, DATA_VALID, BUSY, FRAME_ERR} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h want 0",
                     {SELECT_REG, dut_fields, DATA_VALID, BUSY, FRAME_ERR});
        end
        repeat (3) @(negedge SPI_CLK);
        RSTB = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 20; i++) begin
                @(negedge SPI_CLK);
                if (DATA_VALID !== 1'b0 || BUSY !== 1'b0) bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL reset_idle: got %0d active edges want 0", bad);
            end
        end
    endtask

    task automatic test_frame_ph7();
        set_src(10'h155, 10'h2AA, 10'h3FF, 10'h000, 10'h123, 3'd5, 3'd0);
        capture(7, 1'b0);
        n_cmp++;
        if (cap_lat != 58) begin
            n_err++; $display("FAIL ph7_latency: got %0d want 58", cap_lat);
        end
        n_cmp++;
        if (cap_busy !== 1'b1) begin
            n_err++; $display("FAIL ph7_busy: got %b want 1", cap_busy);
        end
        n_cmp++;
        if (dut_fields !== exp_fields) begin
            n_err++; $display("FAIL ph7_fields: got %h want %h", dut_fields, exp_fields);
        end
        n_cmp++;
        if (FRAME_ERR !== 1'b0 || BUSY !== 1'b0) begin
            n_err++; $display("FAIL ph7_err_busy: got %b%b want 00", FRAME_ERR, BUSY);
        end
        @(negedge SPI_CLK); DATA_READY = 1'b1;
        @(negedge SPI_CLK); DATA_READY = 1'b0;
        n_cmp++;
        if (DATA_VALID !== 1'b0 || SELECT_REG !== 3'd0) begin
            n_err++;
            $display("FAIL ph7_accept: got dv=%b sel=%0d want dv=0 sel=0", DATA_VALID, SELECT_REG);
        end
    endtask

    task automatic test_frame_ph0();
        int seq_ok;
        set_src(10'h155, 10'h2AA, 10'h3FF, 10'h000, 10'h123, 3'd5, 3'd0);
        capture(0, 1'b0);
        n_cmp++;
        if (cap_lat != 65) begin
            n_err++; $display("FAIL ph0_latency: got %0d want 65", cap_lat);
        end
        n_cmp++;
        if (dut_fields !== exp_fields) begin
            n_err++; $display("FAIL ph0_fields: got %h want %h", dut_fields, exp_fields);
        end
        seq_ok = (sel_seq.size() == 6);
        foreach (sel_seq[k]) if (sel_seq[k] != 3'(k + 1)) seq_ok = 0;
        n_cmp++;
        if (seq_ok != 1) begin
            n_err++; $display("FAIL ph0_select_seq: got %0d steps want 6 steps 1..6", sel_seq.size());
        end
        n_cmp++;
        if (sel_bad != 0) begin
            n_err++; $display("FAIL ph0_select_phase: got %0d off-PH7 changes want 0", sel_bad);
        end
        @(negedge SPI_CLK); DATA_READY = 1'b1;
        @(negedge SPI_CLK); DATA_READY = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int p = int'($urandom_range(0, 7));
            rand_src();
            src_pad = (it == 0) ? 3'b101 : 3'($urandom);
            capture(p, 1'b0);
            n_cmp++;
            if (cap_lat != 65 - p) begin
                n_err++; $display("FAIL rand_latency: ph=%0d got %0d want %0d", p, cap_lat, 65 - p);
            end
            n_cmp++;
            if (dut_fields !== exp_fields) begin
                n_err++; $display("FAIL rand_fields: got %h want %h", dut_fields, exp_fields);
            end
            n_cmp++;
            if (FRAME_ERR !== exp_err) begin
                n_err++; $display("FAIL rand_frame_err: got %b want %b", FRAME_ERR, exp_err);
            end
            @(negedge SPI_CLK); DATA_READY = 1'b1;
            @(negedge SPI_CLK); DATA_READY = 1'b0;
        end
    endtask

    task automatic test_hold();
        logic [52:0] held;
        int bad = 0;
        rand_src();
        src_pad = 3'b010;
        capture(int'($urandom_range(0, 7)), 1'b0);
        held = exp_fields;
        for (int i = 0; i < 20; i++) begin
            @(negedge SPI_CLK);
            rand_src();
            src_pad = 3'($urandom);
            if (dut_fields !== held || FRAME_ERR !== 1'b1 || DATA_VALID !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL hold_done: got %0d changed edges want 0", bad);
        end
        DATA_READY = 1'b1;
        @(negedge SPI_CLK); DATA_READY = 1'b0;
        n_cmp++;
        if (DATA_VALID !== 1'b0 || BUSY !== 1'b0 || SELECT_REG !== 3'd0) begin
            n_err++;
            $display("FAIL hold_accept: got dv=%b busy=%b sel=%0d want 0 0 0",
                     DATA_VALID, BUSY, SELECT_REG);
        end
        repeat (5) @(negedge SPI_CLK);
        n_cmp++;
        if (dut_fields !== held) begin
            n_err++; $display("FAIL hold_idle_fields: got %h want %h", dut_fields, held);
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        set_src(10'h3A5, 10'h0F0, 10'h111, 10'h2C3, 10'h07E, 3'd6, 3'd0);
        wait_ph(7);
        START = 1'b1;
        // START edge enters RX, CNT=0 is edge 2, so edge 32 is CNT=30.
        for (int i = 1; i <= 32; i++) begin
            @(negedge SPI_CLK);
            START = 1'b0;
        end
        n_cmp++;
        if (BUSY !== 1'b1) begin
            n_err++; $display("FAIL midrx_busy: got %b want 1", BUSY);
        end
        RSTB = 1'b0;
        #1;
        n_cmp++;
        if ({SELECT_REG, dut_fields, DATA_VALID, BUSY, FRAME_ERR} !== '0) begin
            n_err++;
            $display("FAIL midrx_reset_outputs: got %h want 0",
                     {SELECT_REG, dut_fields, DATA_VALID, BUSY, FRAME_ERR});
        end
        @(negedge SPI_CLK);
        RSTB = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge SPI_CLK);
            if (DATA_VALID !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL midrx_no_partial: got %0d active edges want 0", bad);
        end
        capture(3, 1'b0);
        n_cmp++;
        if (cap_lat != 62 || dut_fields !== exp_fields) begin
            n_err++;
            $display("FAIL midrx_recapture: got lat=%0d %h want lat=62 %h",
                     cap_lat, dut_fields, exp_fields);
        end
        @(negedge SPI_CLK); DATA_READY = 1'b1;
        @(negedge SPI_CLK); DATA_READY = 1'b0;
    endtask

    task automatic test_ignored_start();
        int bad = 0;
        rand_src();
        src_pad = 3'd0;
        capture(7, 1'b1);
        n_cmp++;
        if (cap_lat != 58 || dut_fields !== exp_fields) begin
            n_err++;
            $display("FAIL rx_start_ignored: got lat=%0d %h want lat=58 %h",
                     cap_lat, dut_fields, exp_fields);
        end
        @(negedge SPI_CLK);
        START = 1'b1; DATA_READY = 1'b1;
        @(negedge SPI_CLK);
        START = 1'b0; DATA_READY = 1'b0;
        n_cmp++;
        if (DATA_VALID !== 1'b0) begin
            n_err++; $display("FAIL done_accept: got dv=%b want 0", DATA_VALID);
        end
        for (int i = 0; i < 80; i++) begin
            @(negedge SPI_CLK);
            if (DATA_VALID !== 1'b0 || BUSY !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL done_start_dropped: got %0d active edges want 0", bad);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame_ph7();
        test_frame_ph0();
        test_random();
        test_hold();
        test_reset_mid();
        test_ignored_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cnt_ser_receiver.md
CNT_SER_RECEIVER -- requirements
Module: cnt_ser_receiver

Interface
REQ-001 SHALL have ports: SPI_CLK  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have ports: RSTB  in  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have ports: START  in  1  request one 56-bit frame capture; sampled on SPI_CLK.
REQ-004 SHALL have ports: CNT_SER  in  1  serial counter bit from the channel digital block; registered on SPI_CLK at the source.
REQ-005 SHALL have ports: SELECT_REG  out  3  byte index driven to the channel serializer; registered.
REQ-006 SHALL have ports: CA_O, CB_O, CC_O, CD_O, CE_O  out  10 each  recovered counter values.
REQ-007 SHALL have ports: TRIG_CNT_O  out  3  recovered trigger count.
REQ-008 SHALL have ports: DATA_VALID  out  1  frame held and stable; DATA_READY  in  1  consumer accept.
REQ-009 SHALL have ports: BUSY  out  1  high in WAIT or RX; FRAME_ERR  out  1  pad bits nonzero, qualified by DATA_VALID.

Function
REQ-010 SHALL keep a 3-bit phase counter PH, reset to 0, incremented every edge, mirroring the serializer's free-running bit position.
REQ-011 Protocol: at an edge with PH=p, the source launches byte SELECT_REG, bit p onto CNT_SER; the receiver samples that bit one edge later.
REQ-012 SHALL use states IDLE, WAIT, RX, DONE.
REQ-013 IDLE: START=1 -> WAIT. START is ignored in every other state.
REQ-014 WAIT: at the edge where PH=7, SHALL set SELECT_REG<=0, clear bit count CNT<=0 and go to RX.
REQ-015 RX: every edge CNT<=CNT+1; the first RX edge (CNT=0, PH=0) launches only and SHALL NOT shift.
REQ-016 RX edges CNT=1..56: SHALL shift the frame register left and insert CNT_SER at the LSB.
REQ-017 RX edges with PH=7 and SELECT_REG<6: SHALL increment SELECT_REG, so byte k is selected before its PH=0 launch edge.
REQ-018 At RX edge CNT=56, SHALL load the outputs from frame X[55:0]: CA=X[9:0], CB=X[19:10], CC=X[29:20], CD=X[39:30], CE=X[49:40], TRIG_CNT=X[52:50]; FRAME_ERR=|X[55:53]; then go to DONE.
REQ-019 DONE: DATA_VALID=1 and data outputs frozen; DATA_READY=1 -> IDLE with DATA_VALID<=0 and SELECT_REG<=0.
REQ-020 START coinciding with DATA_READY in DONE SHALL be dropped; the consumer re-asserts START.
REQ-021 Latency from the START edge to DATA_VALID: 58 to 65 edges, depending on PH at START.
REQ-022 Data outputs SHALL hold their last frame while not in DONE; DATA_VALID is the only qualifier.

Reset
REQ-023 RSTB low, at any time including mid-RX: state=IDLE; PH, CNT, SELECT_REG=0; all data outputs, DATA_VALID, BUSY, FRAME_ERR=0.
REQ-024 After reset release, the first capture SHALL require a fresh START; a partial frame SHALL never be presented.

Structure
REQ-025 Package cnt_rx_pkg SHALL hold the state enum, FRAME_BITS=56, NUM_BYTES=7, and the field LSB offsets 0/10/20/30/40/50/53.
REQ-026 The phase mirror plus bit counter SHALL be sub-module cnt_rx_phase; the FSM and frame register stay top-level.
REQ-027 No other clock or clock-domain crossing SHALL exist.

Verification (bench instantiates a behavioural model of the channel serializer sharing SPI_CLK/RSTB)
REQ-028 Source CA=0x155, CB=0x2AA, CC=0x3FF, CD=0x000, CE=0x123, trig=5; START with PH=7 -> DATA_VALID after 58 edges, fields exact, FRAME_ERR=0.
REQ-029 Same frame with START at PH=0 -> DATA_VALID after 65 edges; SELECT_REG steps 0..6, each change on a PH=7 edge.
REQ-030 Source injects pad bits 3'b101 -> FRAME_ERR=1 and fields still decoded.
REQ-031 Hold DATA_READY=0 for 20 edges while the source changes its counters -> outputs unchanged; pulse DATA_READY -> IDLE next edge.
REQ-032 Pulse RSTB low at CNT=30 -> all outputs 0 immediately; a new START then yields the correct frame.
REQ-033 START during RX and START together with DATA_READY in DONE -> both ignored; exactly one frame is delivered per accepted START.
